// File: rtl/program_loader.sv
// program_loader
//
// Initiator side of the core's program-load handshake. A load session is
// opened with `start` + `word_count`. Bytes then arrive on a valid/ready
// stream and are packed little-endian into 32-bit words. Each word is written
// to instruction memory at byte address word_idx*4. Once every word is
// written, `prog_ready` is raised and held until the core returns `prog_ack`.
//
// Ports
//   clk          rising-edge clock
//   arst_n       synchronous active-low reset
//   start        one-cycle request to open a session (ignored while busy)
//   word_count   number of words to load, sampled with an accepted start
//   rx_data      stream byte
//   rx_valid     rx_data is valid
//   rx_ready     loader accepts a byte this cycle
//   mem_w_en     instruction-memory write strobe
//   mem_wr_addr  byte address of the write
//   mem_data_in  word to write (holds its value between writes)
//   prog_ready   program loaded, core may start fetching
//   prog_ack     core has seen prog_ready (used only while handing off)
//   busy         session in progress
//   done         one-cycle pulse at session end
//   error        one-cycle pulse when word_count exceeds memory capacity
//
// Stream handshake: a byte transfers on every rising edge where
// rx_valid && rx_ready. rx_ready is registered and does not depend on
// rx_valid. A source with rx_valid=1 must hold rx_data stable until the
// transfer happens.

module program_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  word_count,
    input  logic [BYTE_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  prog_ready,
    input  logic                  prog_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [LEN_WIDTH-1:0] WORD_CAP = LEN_WIDTH'(MEM_DEPTH / 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_HANDOFF,
        S_DONE
    } state_t;

    state_t                          state;
    logic [LEN_WIDTH-1:0]            count_q;
    logic [LEN_WIDTH-1:0]            word_idx;
    logic [1:0]                      byte_idx;
    // Only lanes 0..2 are buffered; lane 3 goes straight into mem_data_in.
    logic [DATA_WIDTH-BYTE_WIDTH-1:0] word_buf;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state       <= S_IDLE;
            count_q     <= '0;
            word_idx    <= '0;
            byte_idx    <= '0;
            word_buf    <= '0;
            rx_ready    <= 1'b0;
            mem_w_en    <= 1'b0;
            mem_wr_addr <= '0;
            mem_data_in <= '0;
            prog_ready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            mem_w_en <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (word_count > WORD_CAP) begin
                            error <= 1'b1;
                        end else begin
                            count_q  <= word_count;
                            word_idx <= '0;
                            byte_idx <= '0;
                            busy     <= 1'b1;
                            if (word_count == '0) begin
                                prog_ready <= 1'b1;
                                state      <= S_HANDOFF;
                            end else begin
                                rx_ready <= 1'b1;
                                state    <= S_RECV;
                            end
                        end
                    end
                end

                S_RECV: begin
                    if (rx_valid && rx_ready) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[BYTE_WIDTH-1:0]              <= rx_data;
                            2'd1: word_buf[2*BYTE_WIDTH-1:BYTE_WIDTH]   <= rx_data;
                            2'd2: word_buf[3*BYTE_WIDTH-1:2*BYTE_WIDTH] <= rx_data;
                            default: begin
                                // Last lane: present the write in the next
                                // cycle and stop accepting until it is done.
                                mem_data_in <= {rx_data, word_buf};
                                mem_wr_addr <= ADDR_WIDTH'({word_idx, 2'b00});
                                mem_w_en    <= 1'b1;
                                rx_ready    <= 1'b0;
                                state       <= S_WRITE;
                            end
                        endcase
                    end
                end

                S_WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    if (word_idx + 1'b1 == count_q) begin
                        prog_ready <= 1'b1;
                        state      <= S_HANDOFF;
                    end else begin
                        rx_ready <= 1'b1;
                        state    <= S_RECV;
                    end
                end

                S_HANDOFF: begin
                    if (prog_ack) begin
                        prog_ready <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/program_loader.md
# program_loader

Initiator side of the core's program-load handshake. Accepts a byte stream on a valid/ready interface and packs the bytes little-endian into 32-bit words. Writes the words into instruction memory via its write port, then raises `prog_ready` and holds it until the core's program counter returns `prog_ack`. It sits outside `microprocessor_top` and drives that block's instruction-memory write port and its `prog_ready` input.

## Interface
Parameters:
- `DATA_WIDTH`, 32, instruction word width; fixed at 4 bytes.
- `BYTE_WIDTH`, 8, width of one stream byte.
- `ADDR_WIDTH`, 32, instruction-memory byte-address width.
- `MEM_DEPTH`, 1024, instruction-memory capacity in bytes; word capacity is `MEM_DEPTH/4`.
- `LEN_WIDTH`, 16, width of the word-count input.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `arst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to begin a load session.
- `word_count`  in  LEN_WIDTH  number of words to load; sampled in the cycle `start` is accepted.
- `rx_data`  in  BYTE_WIDTH  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `mem_w_en`  out  1  instruction-memory write strobe.
- `mem_wr_addr`  out  ADDR_WIDTH  byte address of the write.
- `mem_data_in`  out  DATA_WIDTH  word to write.
- `prog_ready`  out  1  program loaded; core may start fetching.
- `prog_ack`  in  1  core has seen `prog_ready`.
- `busy`  out  1  session in progress.
- `done`  out  1  one-cycle pulse at session end.
- `error`  out  1  one-cycle pulse when `word_count` exceeds capacity.

## Operation
- All outputs are registered. Reset value of every output is 0. Internal counters also reset to 0.
- States:
  - IDLE
    - `start`=1 with `word_count` ≤ `MEM_DEPTH/4` latches the count, clears the word index and byte index, and goes to RECV.
    - If `word_count`=0, it goes directly to HANDOFF.
    - If `word_count` > `MEM_DEPTH/4`, it pulses `error`, stays in IDLE, and `busy` stays 0.
  - RECV
    - `rx_ready`=1.
    - On each `rx_valid && rx_ready`, the byte goes into word lane `byte_idx` (byte 0 → [7:0], byte 3 → [31:24]), and `byte_idx` increments modulo 4.
    - On accepting lane 3, the FSM goes to WRITE.
  - WRITE (one cycle)
    - `rx_ready`=0.
    - `mem_w_en`=1, `mem_wr_addr`=`word_idx*4`, `mem_data_in`=the assembled word.
    - `word_idx` increments. If it reaches `word_count`, go to HANDOFF; otherwise return to RECV.
  - HANDOFF
    - `prog_ready`=1 and `rx_ready`=0.
    - `prog_ready` holds until `prog_ack`=1 is sampled, then the FSM goes to DONE.
  - DONE (one cycle)
    - `prog_ready`=0 and `done`=1.
    - Returns to IDLE.
- `busy`=1 in RECV, WRITE, HANDOFF and DONE.
- `start` is ignored while `busy`=1.
- Bytes presented while not in RECV are not consumed; the source must hold them.
- `prog_ack` is ignored outside HANDOFF.
- Address arithmetic is unsigned. `word_idx` never exceeds `MEM_DEPTH/4`, so `mem_wr_addr` never reaches `MEM_DEPTH`.
- `mem_data_in` holds its last value when `mem_w_en`=0.
- Reset mid-session returns the FSM to IDLE and drops all outputs to 0 on the next edge. Memory contents already written are not cleared, and a partial word is discarded.

## Timing
- `start` accepted at edge E → `busy`=1 and `rx_ready`=1 from E+1.
- With `word_count`=0, `prog_ready`=1 from E+1.
- 4th byte of a word accepted at edge N → `mem_w_en`=1 in cycle N+1, with `rx_ready`=0 in that cycle.
- `rx_ready` returns to 1 at N+2 unless the session is complete.
- Peak throughput is 5 cycles per word.
- Last WRITE cycle at edge W → `prog_ready`=1 from W+1.
- `prog_ack`=1 sampled at edge A → `prog_ready`=0 and `done`=1 in cycle A+1.
- `busy`=0 and the block is ready for a new `start` from A+2.
- If `prog_ack` is already 1 when `prog_ready` rises, `prog_ready` is high for exactly one cycle.
- `error` is asserted in the cycle after the rejected `start`.

## Test plan
- **Basic load.** Reset, then `start` with `word_count`=2, stream bytes 0x13,0x05,0x10,0x00,0xB3,0x85,0xA5,0x00 with `rx_valid` always high.
  - Writes 0x00100513 @0x0 and 0x00A585B3 @0x4, one cycle each.
  - `prog_ready` rises the cycle after the second write.
  - `prog_ack` 3 cycles later → `done` pulse, then `busy`=0.
- **Back-pressure and gaps.** Same stream, with `rx_valid` toggling randomly and bytes presented during WRITE.
  - Identical memory writes, with no byte lost or duplicated.
  - `rx_ready`=0 in every WRITE cycle.
- **Capacity boundary.**
  - `word_count`=256 (`MEM_DEPTH`=1024): the last write is @0x3FC and `error` stays 0.
  - `word_count`=257: `error` pulses for one cycle, `busy` stays 0, and no write occurs.
- **Zero length and early ack.** `word_count`=0 with `prog_ack` tied high.
  - `prog_ready` is high for exactly one cycle, then `done`, with no `mem_w_en`.
- **Reset mid-session.**
  - Pull `arst_n` low after 6 bytes of a 3-word load: all outputs are 0 at the next edge.
  - A new `start` with `word_count`=1 writes its word @0x0.
- **Start while busy.** Assert `start` with `word_count`=5 during HANDOFF of a 1-word session.
  - Ignored: after `done` the FSM is in IDLE and no further writes occur.
